// File: rtl/playback_controller.sv
// Play/pause/restart sequencer for a song timer: counts elapsed hundredths of a second while
// playing, stops at the song length and reports completion. All outputs are registered.
module playback_controller #(
    parameter int unsigned PRESCALE = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_btn,
    input  logic        restart_btn,
    input  logic [13:0] song_len_cs,
    output logic        play,
    output logic        reset_player,
    output logic        song_done,
    output logic        cs_tick,
    output logic [1:0]  state,
    output logic [13:0] elapsed_cs
);

    localparam logic [18:0] PRESC_LAST = 19'(PRESCALE - 1);
    localparam logic [13:0] MAX_CS     = 14'd9999;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPlaying = 2'd1,
        StPaused  = 2'd2,
        StDone    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [18:0] presc_q, presc_d;
    logic [13:0] elapsed_q, elapsed_d;
    logic        play_q, play_d;
    logic        reset_player_q, reset_player_d;
    logic        song_done_q, song_done_d;
    logic        cs_tick_q, cs_tick_d;
    logic [13:0] len_eff;

    assign len_eff = (song_len_cs > MAX_CS) ? MAX_CS : song_len_cs;

    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        elapsed_d      = elapsed_q;
        reset_player_d = 1'b0;
        song_done_d    = 1'b0;
        cs_tick_d      = 1'b0;

        if (restart_btn) begin
            state_d        = StIdle;
            presc_d        = '0;
            elapsed_d      = '0;
            reset_player_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (play_btn) state_d = StPlaying;
                end
                StPlaying: begin
                    // Completion beats both pause and the tick; the pause edge does not
                    // advance the prescaler so a resume continues exactly mid-tick.
                    if (elapsed_q >= len_eff) begin
                        state_d     = StDone;
                        presc_d     = '0;
                        song_done_d = 1'b1;
                    end else if (play_btn) begin
                        state_d = StPaused;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d   = '0;
                        elapsed_d = elapsed_q + 14'd1;
                        cs_tick_d = 1'b1;
                    end else begin
                        presc_d = presc_q + 19'd1;
                    end
                end
                StPaused: begin
                    if (play_btn) state_d = StPlaying;
                end
                StDone: begin
                    if (play_btn) begin
                        state_d        = StPlaying;
                        presc_d        = '0;
                        elapsed_d      = '0;
                        reset_player_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        play_d = (state_d == StPlaying);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            presc_q        <= '0;
            elapsed_q      <= '0;
            play_q         <= 1'b0;
            reset_player_q <= 1'b0;
            song_done_q    <= 1'b0;
            cs_tick_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            elapsed_q      <= elapsed_d;
            play_q         <= play_d;
            reset_player_q <= reset_player_d;
            song_done_q    <= song_done_d;
            cs_tick_q      <= cs_tick_d;
        end
    end

    assign state        = state_q;
    assign elapsed_cs   = elapsed_q;
    assign play         = play_q;
    assign reset_player = reset_player_q;
    assign song_done    = song_done_q;
    assign cs_tick      = cs_tick_q;

endmodule

// File: tb/tb_playback_controller.sv
// Bench for playback_controller: directed scenarios plus a randomized run against a model that
// tracks total playing cycles and derives elapsed time arithmetically.
module tb_playback_controller;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        play_btn = 1'b0;
    logic        restart_btn = 1'b0;
    logic [13:0] song_len_cs = 14'd0;
    logic        play, reset_player, song_done, cs_tick;
    logic [1:0]  state;
    logic [13:0] elapsed_cs;

    int vectors = 0;
    int errors  = 0;

    playback_controller #(.PRESCALE(P)) dut (
        .clk         (clk),
        .rst         (rst),
        .play_btn    (play_btn),
        .restart_btn (restart_btn),
        .song_len_cs (song_len_cs),
        .play        (play),
        .reset_player(reset_player),
        .song_done   (song_done),
        .cs_tick     (cs_tick),
        .state       (state),
        .elapsed_cs  (elapsed_cs)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_play();
        play_btn = 1'b1;
        tick();
        play_btn = 1'b0;
    endtask

    task automatic pulse_restart();
        restart_btn = 1'b1;
        tick();
        restart_btn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        vectors++;
        if ({state, elapsed_cs, play, reset_player, song_done, cs_tick} !== 20'd0) begin
            errors++;
            $display("FAIL reset_values: got state=%0d elapsed=%0d play=%b rp=%b done=%b tick=%b, want all 0",
                     state, elapsed_cs, play, reset_player, song_done, cs_tick);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (state !== 2'd0 || play !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got state=%0d play=%b, want 0 0", state, play);
        end
    endtask

    task automatic test_basic_play();
        song_len_cs = 14'd3;
        pulse_play();
        vectors++;
        if (state !== 2'd1 || play !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: got state=%0d play=%b, want 1 1", state, play);
        end
        for (int k = 1; k <= 12; k++) begin
            logic        exp_tick;
            logic [13:0] exp_el;
            tick();
            exp_tick = (k % 4 == 0);
            exp_el   = 14'(k / 4);
            vectors++;
            if (cs_tick !== exp_tick || elapsed_cs !== exp_el || song_done !== 1'b0) begin
                errors++;
                $display("FAIL basic_step%0d: got tick=%b elapsed=%0d done=%b, want %b %0d 0",
                         k, cs_tick, elapsed_cs, song_done, exp_tick, exp_el);
            end
        end
        tick();
        vectors++;
        if (song_done !== 1'b1 || state !== 2'd3 || play !== 1'b0 || elapsed_cs !== 14'd3) begin
            errors++;
            $display("FAIL basic_done: got done=%b state=%0d play=%b elapsed=%0d, want 1 3 0 3",
                     song_done, state, play, elapsed_cs);
        end
        tick();
        vectors++;
        if (song_done !== 1'b0 || elapsed_cs !== 14'd3 || state !== 2'd3) begin
            errors++;
            $display("FAIL basic_hold: got done=%b elapsed=%0d state=%0d, want 0 3 3",
                     song_done, elapsed_cs, state);
        end
    endtask

    task automatic test_pause_resume();
        pulse_restart();
        song_len_cs = 14'd100;
        pulse_play();
        repeat (6) tick();
        vectors++;
        if (elapsed_cs !== 14'd1) begin
            errors++;
            $display("FAIL pause_pre: got elapsed=%0d, want 1", elapsed_cs);
        end
        pulse_play();
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (elapsed_cs !== 14'd1 || state !== 2'd2 || play !== 1'b0 || cs_tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold%0d: got elapsed=%0d state=%0d play=%b tick=%b, want 1 2 0 0",
                         i, elapsed_cs, state, play, cs_tick);
            end
            tick();
        end
        pulse_play();
        tick();
        vectors++;
        if (elapsed_cs !== 14'd1 || cs_tick !== 1'b0 || state !== 2'd1) begin
            errors++;
            $display("FAIL resume_1: got elapsed=%0d tick=%b state=%0d, want 1 0 1",
                     elapsed_cs, cs_tick, state);
        end
        tick();
        vectors++;
        if (elapsed_cs !== 14'd2 || cs_tick !== 1'b1) begin
            errors++;
            $display("FAIL resume_2: got elapsed=%0d tick=%b, want 2 1", elapsed_cs, cs_tick);
        end
    endtask

    task automatic test_done_replay();
        pulse_restart();
        song_len_cs = 14'd1;
        pulse_play();
        for (int i = 0; i < 50 && state !== 2'd3; i++) tick();
        vectors++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL replay_reach_done: got state=%0d, want 3", state);
        end
        pulse_play();
        vectors++;
        if (reset_player !== 1'b1 || elapsed_cs !== 14'd0 || state !== 2'd1 || play !== 1'b1) begin
            errors++;
            $display("FAIL replay: got rp=%b elapsed=%0d state=%0d play=%b, want 1 0 1 1",
                     reset_player, elapsed_cs, state, play);
        end
        tick();
        vectors++;
        if (reset_player !== 1'b0) begin
            errors++;
            $display("FAIL replay_rp_width: got rp=%b, want 0", reset_player);
        end
    endtask

    task automatic test_restart_priority();
        song_len_cs = 14'd50;
        repeat (5) tick();
        play_btn    = 1'b1;
        restart_btn = 1'b1;
        tick();
        play_btn    = 1'b0;
        restart_btn = 1'b0;
        vectors++;
        if (state !== 2'd0 || elapsed_cs !== 14'd0 || reset_player !== 1'b1 || play !== 1'b0) begin
            errors++;
            $display("FAIL restart_prio: got state=%0d elapsed=%0d rp=%b play=%b, want 0 0 1 0",
                     state, elapsed_cs, reset_player, play);
        end
        tick();
        vectors++;
        if (reset_player !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL restart_after: got rp=%b state=%0d, want 0 0", reset_player, state);
        end
    endtask

    task automatic test_zero_len();
        song_len_cs = 14'd0;
        pulse_play();
        vectors++;
        if (state !== 2'd1 || song_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_start: got state=%0d done=%b, want 1 0", state, song_done);
        end
        tick();
        vectors++;
        if (state !== 2'd3 || song_done !== 1'b1 || elapsed_cs !== 14'd0) begin
            errors++;
            $display("FAIL zero_done: got state=%0d done=%b elapsed=%0d, want 3 1 0",
                     state, song_done, elapsed_cs);
        end
        tick();
        vectors++;
        if (state !== 2'd3 || song_done !== 1'b0 || elapsed_cs !== 14'd0) begin
            errors++;
            $display("FAIL zero_after: got state=%0d done=%b elapsed=%0d, want 3 0 0",
                     state, song_done, elapsed_cs);
        end
    endtask

    task automatic test_async_reset();
        pulse_restart();
        song_len_cs = 14'd100;
        pulse_play();
        repeat (8) tick();
        vectors++;
        if (elapsed_cs !== 14'd2 || state !== 2'd1) begin
            errors++;
            $display("FAIL areset_pre: got elapsed=%0d state=%0d, want 2 1", elapsed_cs, state);
        end
        #3 rst = 1'b0;
        #1;
        vectors++;
        if ({state, elapsed_cs, play, reset_player, song_done, cs_tick} !== 20'd0) begin
            errors++;
            $display("FAIL areset_immediate: got state=%0d elapsed=%0d play=%b rp=%b done=%b tick=%b, want all 0",
                     state, elapsed_cs, play, reset_player, song_done, cs_tick);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (song_done !== 1'b0 || reset_player !== 1'b0) begin
                errors++;
                $display("FAIL areset_no_pulse%0d: got done=%b rp=%b, want 0 0",
                         i, song_done, reset_player);
            end
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (state !== 2'd0 || elapsed_cs !== 14'd0) begin
            errors++;
            $display("FAIL areset_release: got state=%0d elapsed=%0d, want 0 0", state, elapsed_cs);
        end
    endtask

    // Model: elapsed time is total playing cycles divided by the prescale.
    task automatic test_random();
        int          mstate = 0;
        int          played = 0;
        int          len_eff;
        int          el;
        logic        e_rp, e_done, e_tick;
        logic [19:0] exp_v, got_v;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        song_len_cs = 14'd5;
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) song_len_cs = 14'($urandom_range(10000, 16383));
            else if (r < 8) song_len_cs = 14'($urandom_range(0, 20));
            play_btn    = ($urandom_range(0, 15) == 0);
            restart_btn = ($urandom_range(0, 199) == 0);
            len_eff = (song_len_cs > 14'd9999) ? 9999 : int'(song_len_cs);
            el      = played / P;
            e_rp = 1'b0; e_done = 1'b0; e_tick = 1'b0;
            if (restart_btn) begin
                mstate = 0; played = 0; e_rp = 1'b1;
            end else if (mstate == 0) begin
                if (play_btn) mstate = 1;
            end else if (mstate == 1) begin
                if (el >= len_eff) begin
                    mstate = 3; played = el * P; e_done = 1'b1;
                end else if (play_btn) begin
                    mstate = 2;
                end else begin
                    played++;
                    e_tick = (played % P == 0);
                end
            end else if (mstate == 2) begin
                if (play_btn) mstate = 1;
            end else begin
                if (play_btn) begin
                    mstate = 1; played = 0; e_rp = 1'b1;
                end
            end
            tick();
            exp_v = {2'(mstate), 14'(played / P), (mstate == 1), e_tick, e_done, e_rp};
            got_v = {state, elapsed_cs, play, cs_tick, song_done, reset_player};
            vectors++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_c%0d: got state=%0d el=%0d play=%b tick=%b done=%b rp=%b, want state=%0d el=%0d play=%b tick=%b done=%b rp=%b",
                         c, got_v[19:18], got_v[17:4], got_v[3], got_v[2], got_v[1], got_v[0],
                         exp_v[19:18], exp_v[17:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
        play_btn    = 1'b0;
        restart_btn = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_play();
        test_pause_resume();
        test_done_replay();
        test_restart_priority();
        test_zero_len();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/playback_controller.md
PLAYBACK_CONTROLLER -- requirements
Module: playback_controller

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 500000, meaning clk cycles per 10 ms tick (50 MHz clock); legal range 2..524287.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port play_btn  input  1  one-cycle pulse, already debounced; requests play/pause toggle.
REQ-005 The block SHALL have port restart_btn  input  1  one-cycle pulse, already debounced; requests a return to the start.
REQ-006 The block SHALL have port song_len_cs  input  14  song length in hundredths of a second; values above 9999 are treated as 9999.
REQ-007 The block SHALL have port play  output  1  high exactly while state is PLAYING; drives the progression display's play input.
REQ-008 The block SHALL have port reset_player  output  1  one-cycle pulse; clears the downstream time display.
REQ-009 The block SHALL have port song_done  output  1  one-cycle pulse on song completion.
REQ-010 The block SHALL have port cs_tick  output  1  one-cycle pulse on each elapsed_cs increment.
REQ-011 The block SHALL have port state  output  2  IDLE=0, PLAYING=1, PAUSED=2, DONE=3.
REQ-012 The block SHALL have port elapsed_cs  output  14  elapsed time in hundredths of a second, 0..9999.

Function
REQ-013 The block SHALL register all outputs; no output is combinational from inputs.
REQ-014 The block SHALL keep a 19-bit prescaler that advances only in PLAYING, counts 0..PRESCALE-1, and wraps to 0 at PRESCALE-1.
REQ-015 On each prescaler wrap, the block SHALL increment elapsed_cs by 1 and pulse cs_tick in the following cycle.
REQ-016 In PAUSED, the block SHALL hold the prescaler and elapsed_cs, so a resume continues mid-tick.
REQ-017 From IDLE, play_btn SHALL move the state to PLAYING; play rises at the same edge.
REQ-018 From PLAYING, play_btn SHALL move the state to PAUSED.
REQ-019 From PAUSED, play_btn SHALL move the state to PLAYING.
REQ-020 From DONE, play_btn SHALL do all of the following at one edge: move to PLAYING, clear elapsed_cs and the prescaler, pulse reset_player.
REQ-021 In any state, restart_btn SHALL do all of the following at one edge: move to IDLE, clear elapsed_cs and the prescaler, pulse reset_player.
REQ-022 When restart_btn and play_btn are high in the same cycle, restart_btn SHALL win and play_btn SHALL be ignored.
REQ-023 In PLAYING, if elapsed_cs >= the effective song length at a clock edge, the block SHALL take precedence over tick logic and do all of the following at that edge: move to DONE, clear the prescaler, pulse song_done, hold elapsed_cs unchanged.
REQ-024 Because of REQ-023, song_done SHALL follow the final increment by exactly one cycle.
REQ-025 elapsed_cs SHALL never exceed the effective song length while PLAYING.
REQ-026 With song_len_cs=0, the first edge in PLAYING SHALL move the block to DONE.
REQ-027 A song_len_cs change mid-play SHALL take effect at the next edge through the >= comparison in REQ-023.
REQ-028 In DONE, the block SHALL hold elapsed_cs and ignore everything except play_btn and restart_btn.
REQ-029 Except as defined in REQ-020 and REQ-021, the block SHALL NOT assert reset_player.

Reset
REQ-030 While rst=0, the block SHALL asynchronously force: state=IDLE, play=0, reset_player=0, song_done=0, cs_tick=0, elapsed_cs=0, prescaler=0.
REQ-031 The block SHALL leave reset synchronously on the first rising clk edge after rst goes high.
REQ-032 A reset asserted mid-PLAYING SHALL abort playback with no song_done pulse and no reset_player pulse.

Verification
REQ-033 (PRESCALE=4, song_len_cs=3) Pulse play_btn -> play=1; cs_tick every 4 cycles; elapsed_cs steps 1, 2, 3; song_done pulses one cycle after elapsed_cs=3; state=3; play=0.
REQ-034 Play, then pause after elapsed_cs=1 with prescaler=2, wait 20 cycles, resume -> elapsed_cs holds 1 during the pause; the next increment comes 2 cycles after resume.
REQ-035 From DONE, pulse play_btn -> one-cycle reset_player pulse; elapsed_cs=0; state=1.
REQ-036 In PLAYING, assert play_btn and restart_btn together -> state=0; elapsed_cs=0; reset_player pulses once; play=0.
REQ-037 With song_len_cs=0, pulse play_btn -> state goes 1 then 3; one song_done pulse; elapsed_cs stays 0.
REQ-038 Drive rst low mid-PLAYING with elapsed_cs=2 -> all outputs go to reset values immediately, without waiting for a clk edge; no song_done pulse.
